// File: rtl/prvp_spi_slave_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : prvp_spi_slave_bus_ctrl
// Description : System-clock transaction controller behind the SPI slave
//               synchronizer. Turns each SPI access into a series of
//               single-word request/grant bus transfers with an
//               auto-incrementing address. Write words arrive on the rx
//               stream and read words leave on the tx stream.
// Revision    : 1.0 - initial release
// ============================================================================
module prvp_spi_slave_bus_ctrl #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_INC       = 4
) (
    input  logic                      sys_clk,
    input  logic                      rst,
    input  logic                      cs_sync,
    input  logic [AXI_ADDR_WIDTH-1:0] address_sync,
    input  logic                      address_valid_sync,
    input  logic                      rd_wr_sync,
    input  logic [DATA_WIDTH-1:0]     rx_data,
    input  logic                      rx_valid,
    output logic                      rx_ready,
    output logic [DATA_WIDTH-1:0]     tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic                      bus_req,
    output logic                      bus_we,
    output logic [AXI_ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0]     bus_wdata,
    input  logic                      bus_gnt,
    input  logic                      bus_rvalid,
    input  logic [DATA_WIDTH-1:0]     bus_rdata,
    output logic [15:0]               word_cnt
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_WR_WAIT = 3'd1;
    localparam logic [2:0] c_WR_REQ  = 3'd2;
    localparam logic [2:0] c_RD_REQ  = 3'd3;
    localparam logic [2:0] c_RD_WAIT = 3'd4;
    localparam logic [2:0] c_RD_HOLD = 3'd5;
    localparam logic [2:0] c_DRAIN   = 3'd6;

    localparam logic [AXI_ADDR_WIDTH-1:0] c_INC = AXI_ADDR_WIDTH'(ADDR_INC);

    logic [2:0]                r_state;
    logic [2:0]                w_next_state;
    logic                      r_end;
    logic                      w_end;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [DATA_WIDTH-1:0]     r_tx_data;
    logic [15:0]               r_word_cnt;
    logic [15:0]               w_cnt_inc;

    // A chip-select release seen while a request is outstanding must still
    // end the access even if cs_sync drops again before the grant, so the
    // end condition is remembered until the FSM is back in IDLE.
    assign w_end     = cs_sync | r_end;
    assign w_cnt_inc = (r_word_cnt == 16'hFFFF) ? r_word_cnt : r_word_cnt + 16'd1;

    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign tx_data   = r_tx_data;
    assign word_cnt  = r_word_cnt;

    // State register plus sticky end-of-access flag
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_end   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_end   <= (r_state != c_IDLE) && (w_next_state != c_IDLE) && w_end;
        end
    end

    // Next-state decode; chip-select release takes priority over data handshakes
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (address_valid_sync && !cs_sync) begin
                    w_next_state = rd_wr_sync ? c_RD_REQ : c_WR_WAIT;
                end
            end
            c_WR_WAIT: begin
                if (w_end) begin
                    w_next_state = c_IDLE;
                end else if (rx_valid) begin
                    w_next_state = c_WR_REQ;
                end
            end
            c_WR_REQ: begin
                if (bus_gnt) begin
                    w_next_state = w_end ? c_IDLE : c_WR_WAIT;
                end
            end
            c_RD_REQ: begin
                if (bus_gnt) begin
                    w_next_state = w_end ? c_DRAIN : c_RD_WAIT;
                end
            end
            c_RD_WAIT: begin
                // Data arriving in the same cycle as the release is simply dropped
                if (w_end) begin
                    w_next_state = bus_rvalid ? c_IDLE : c_DRAIN;
                end else if (bus_rvalid) begin
                    w_next_state = c_RD_HOLD;
                end
            end
            c_RD_HOLD: begin
                if (w_end) begin
                    w_next_state = c_IDLE;
                end else if (tx_ready) begin
                    w_next_state = c_RD_REQ;
                end
            end
            c_DRAIN: begin
                if (bus_rvalid) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // Stream and bus strobes decoded purely from the registered state
    always_comb begin
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        bus_req  = 1'b0;
        bus_we   = 1'b0;
        case (r_state)
            c_WR_WAIT: rx_ready = 1'b1;
            c_WR_REQ: begin
                bus_req = 1'b1;
                bus_we  = 1'b1;
            end
            c_RD_REQ:  bus_req  = 1'b1;
            c_RD_HOLD: tx_valid = 1'b1;
            default: begin
                rx_ready = 1'b0;
            end
        endcase
    end

    // Address, write data, read data and word counter updates
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_tx_data  <= '0;
            r_word_cnt <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (address_valid_sync && !cs_sync) begin
                        r_addr     <= address_sync;
                        r_word_cnt <= '0;
                    end
                end
                c_WR_WAIT: begin
                    if (!w_end && rx_valid) begin
                        r_wdata <= rx_data;
                    end
                end
                c_WR_REQ: begin
                    // A granted write completes even when the access is ending
                    if (bus_gnt) begin
                        r_addr     <= r_addr + c_INC;
                        r_word_cnt <= w_cnt_inc;
                    end
                end
                c_RD_WAIT: begin
                    if (!w_end && bus_rvalid) begin
                        r_tx_data  <= bus_rdata;
                        r_word_cnt <= w_cnt_inc;
                    end
                end
                c_RD_HOLD: begin
                    // The handshake completes even alongside a chip-select release
                    if (tx_ready) begin
                        r_addr <= r_addr + c_INC;
                    end
                end
                default: begin
                    r_addr <= r_addr;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/prvp_spi_slave_bus_ctrl.md
# prvp_spi_slave_bus_ctrl

Sys-clock-domain transaction controller downstream of the SPI slave synchronizer. It consumes the synchronized chip-select, address, address-valid pulse and read/write flag, and converts each SPI access into a sequence of single-word request/grant bus transactions with auto-incrementing address. Write data arrives from the SPI receive path, and read data is returned toward the SPI transmit path, both over valid/ready streams.

## Interface
- AXI_ADDR_WIDTH, 32, width of address_sync and bus_addr
- DATA_WIDTH, 32, width of all data paths
- ADDR_INC, 4, address increment applied after each completed word
- sys_clk  in  1  system clock; single clock domain for the whole block
- rst  in  1  asynchronous, active-high reset
- cs_sync  in  1  synchronized chip select, active low
- address_sync  in  AXI_ADDR_WIDTH  start address, stable while address_valid_sync pulses
- address_valid_sync  in  1  one-cycle pulse marking a new access
- rd_wr_sync  in  1  1 = read access, 0 = write access
- rx_data  in  DATA_WIDTH  write word from the SPI side
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  block accepts rx_data
- tx_data  out  DATA_WIDTH  read word toward the SPI side
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  SPI side accepts tx_data
- bus_req  out  1  bus request, held until bus_gnt
- bus_we  out  1  1 = write transaction
- bus_addr  out  AXI_ADDR_WIDTH  transaction address
- bus_wdata  out  DATA_WIDTH  write data
- bus_gnt  in  1  request accepted this cycle
- bus_rvalid  in  1  read data valid; earliest one cycle after the bus_gnt cycle
- bus_rdata  in  DATA_WIDTH  read data
- word_cnt  out  16  words completed in the current access

## Operation
- FSM states: IDLE, WR_WAIT, WR_REQ, RD_REQ, RD_WAIT, RD_HOLD, DRAIN.
- IDLE: on address_valid_sync=1 with cs_sync=0, latch address_sync into the address register, clear word_cnt, and go to RD_REQ if rd_wr_sync=1, otherwise WR_WAIT. address_valid_sync in any other state is ignored.
- WR_WAIT: rx_ready=1. On rx_valid, capture rx_data into bus_wdata and go to WR_REQ.
- WR_REQ: bus_req=1, bus_we=1. On bus_gnt, addr += ADDR_INC, word_cnt += 1, then go to WR_WAIT.
- RD_REQ: bus_req=1, bus_we=0. On bus_gnt, go to RD_WAIT.
- RD_WAIT: on bus_rvalid, register bus_rdata into tx_data, word_cnt += 1, then go to RD_HOLD.
- RD_HOLD: tx_valid=1, tx_data stable. On tx_ready, addr += ADDR_INC, then go to RD_REQ (one-word prefetch).
- cs_sync=1 ends the access:
  - WR_WAIT or RD_HOLD go to IDLE; tx_valid drops and the pending tx word is discarded.
  - WR_REQ or RD_REQ keep bus_req until bus_gnt, then go to DRAIN for a read or IDLE for a write. A granted write still increments word_cnt.
  - RD_WAIT goes to DRAIN. DRAIN waits for bus_rvalid, discards the data, then goes to IDLE.
  - A bus request is never withdrawn before grant.
- Address arithmetic is modulo 2^AXI_ADDR_WIDTH and wraps silently. word_cnt saturates at 16'hFFFF.
- bus_addr always equals the address register. bus_req, bus_we, tx_valid and rx_ready are decoded from the registered state.

## Timing
- Reset values: state IDLE; bus_req, bus_we, rx_ready, tx_valid = 0; bus_addr, bus_wdata, tx_data, word_cnt = 0.
- address_valid_sync at cycle N: bus_req=1 (read) or rx_ready=1 (write) at N+1.
- rx handshake at N: bus_req=1 at N+1.
- bus_gnt at M: bus_req=0 at M+1. For a write, rx_ready=1 at M+1.
- bus_rvalid at R: tx_valid=1 at R+1.
- tx handshake at T: bus_req=1 for the next address at T+1.
- Simultaneous cs_sync=1 and rx_valid in WR_WAIT: the word is not accepted (rx_ready=0 next cycle). Simultaneous cs_sync=1 and tx_ready in RD_HOLD: the handshake completes and no further read is issued.
- rst asserted mid-transaction: immediate return to reset values, including a held bus_req.

## Test plan
- Write of 3 words from 0x1000, data 0xA, 0xB, 0xC, bus_gnt one cycle after req -> bus writes to 0x1000/0x1004/0x1008 with matching data; word_cnt = 3.
- Read from 0x2000, bus_rvalid 2 cycles after gnt, tx_ready after 3 cycles -> tx_data equals bus_rdata; next bus_req at 0x2004 one cycle after the tx handshake.
- Read start at 0xFFFFFFFC with 2 words -> second bus_addr = 0x00000000.
- cs_sync rises while RD_WAIT -> DRAIN, rvalid data dropped, tx_valid stays 0, IDLE after rvalid.
- cs_sync rises in WR_REQ with bus_gnt delayed 5 cycles -> bus_req held until gnt, word_cnt increments, then IDLE.
- rst pulse while bus_req=1 -> bus_req=0 immediately and all outputs at reset values; address_valid_sync pulse while busy -> ignored.
